// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshake, registered result and flags.
// Optional iterative multiplier for opcode 7 is built only when ALU_SEQ_MUL_EN is defined;
// otherwise opcode 7 completes in one cycle with out=0, Cout=0, V=1 (illegal op).
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic [2:0]       opcod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic             V
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       opc_q, opc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [2:0]       cmp_q, cmp_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic [2:0]       flg_q, flg_d;
  logic             ovld_q, ovld_d;
  logic             irdy_q, irdy_d;
`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mc_q, mc_d;
  logic [WIDTH-1:0]   mp_q, mp_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_nxt;
`endif

  logic [WIDTH:0]   sum_w, dif_w;
  logic [2:0]       cmp_now;
  logic [SHW-1:0]   amt;
  logic             ld;
  logic [WIDTH-1:0] res;
  logic             co, ov;
  logic [2:0]       cmp_sel;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_bit;

  // Next-state, datapath iteration and result-load selection
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    cmp_d   = cmp_q;
    out_d   = out_q;
    cout_d  = cout_q;
    v_d     = v_q;
    flg_d   = flg_q;
`ifdef ALU_SEQ_MUL_EN
    mc_d    = mc_q;
    mp_d    = mp_q;
    acc_d   = acc_q;
    acc_nxt = mp_q[0] ? (acc_q + mc_q) : acc_q;
`endif
    ld      = 1'b0;
    res     = '0;
    co      = 1'b0;
    ov      = 1'b0;
    cmp_sel = cmp_q;
    sh_nxt  = '0;
    sh_bit  = 1'b0;

    sum_w   = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
    dif_w   = {1'b0, X} - {1'b0, Y} - {{WIDTH{1'b0}}, Cin};
    amt     = Y[SHW-1:0];
    cmp_now[2] = $signed(X) < $signed(Y);
    cmp_now[1] = (X == Y);
    cmp_now[0] = !cmp_now[2] && !cmp_now[1];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opc_d   = opcod;
          cmp_d   = cmp_now;
          cmp_sel = cmp_now;
          unique case (opcod)
            OP_ADD: begin
              ld = 1'b1; res = sum_w[WIDTH-1:0]; co = sum_w[WIDTH];
              ov = (X[WIDTH-1] == Y[WIDTH-1]) && (sum_w[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
              ld = 1'b1; res = dif_w[WIDTH-1:0]; co = dif_w[WIDTH];
              ov = (X[WIDTH-1] != Y[WIDTH-1]) && (dif_w[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND: begin ld = 1'b1; res = X & Y; end
            OP_OR:  begin ld = 1'b1; res = X | Y; end
            OP_XOR: begin ld = 1'b1; res = X ^ Y; end
            OP_SHL, OP_SHR: begin
              if (amt == '0) begin
                ld = 1'b1; res = X;
              end else begin
                sh_d    = X;
                cnt_d   = CW'(amt);
                state_d = EXEC;
              end
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
              mc_d    = {{WIDTH{1'b0}}, X};
              mp_d    = Y;
              acc_d   = '0;
              cnt_d   = CW'(WIDTH);
              state_d = EXEC;
`else
              ld = 1'b1; ov = 1'b1;
`endif
            end
            default: ;
          endcase
          if (ld) state_d = DONE;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
        if (opc_q == OP_MUL) begin
          acc_d = acc_nxt;
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
          if (cnt_q == CW'(1)) begin
            ld = 1'b1; res = acc_nxt[WIDTH-1:0]; co = |acc_nxt[2*WIDTH-1:WIDTH];
          end
        end else
`endif
        begin
          if (opc_q == OP_SHL) begin
            sh_nxt = sh_q << 1; sh_bit = sh_q[WIDTH-1];
          end else begin
            sh_nxt = sh_q >> 1; sh_bit = sh_q[0];
          end
          sh_d = sh_nxt;
          if (cnt_q == CW'(1)) begin
            ld = 1'b1; res = sh_nxt; co = sh_bit;
          end
        end
        if (ld) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (ld) begin
      out_d  = res;
      cout_d = co;
      v_d    = ov;
      flg_d  = cmp_sel;
    end
    irdy_d = (state_d == IDLE);
    ovld_d = (state_d == DONE);
  end

  // State, operand and result registers; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opc_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      cmp_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      flg_q   <= '0;
      ovld_q  <= 1'b0;
      irdy_q  <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
      mc_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      cmp_q   <= cmp_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      flg_q   <= flg_d;
      ovld_q  <= ovld_d;
      irdy_q  <= irdy_d;
`ifdef ALU_SEQ_MUL_EN
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign in_ready  = irdy_q;
  assign out_valid = ovld_q;
  assign out       = out_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign lt        = flg_q[2];
  assign eq        = flg_q[1];
  assign gt        = flg_q[0];

endmodule
